// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Holds dispatched ALU/branch ops until both source operands are known,
// wakes waiting operands by snooping the ALU and LSB result buses, and
// issues at most one ready op per cycle (lowest index first).
//
// Optional build macro: ALU_RS_WAKEUP_ISSUE_EN
//   defined   - select also sees operands matched on the CDB this cycle and
//               forwards the bus data straight into the issue payload.
//   undefined - select uses registered ready bits only.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), has_misbranch (flush)
//   has_to_rs + in_* : dispatch request and decoded instruction
//   rs_full          : occupancy >= RS_SIZE-1 (combinational)
//   alu_cdb_*/lsb_cdb_* : result broadcasts (valid, tag, data)
//   has_to_alu + op/imm/pc/shamt/rd_robnum/rs1_oprand/rs2_oprand : registered issue
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             has_misbranch,
  input  logic             has_to_rs,
  input  logic [5:0]       in_op,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_shamt,
  input  logic [ROB_W-1:0] in_rd_robnum,
  input  logic             in_rs1_ready,
  input  logic             in_rs2_ready,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic [ROB_W-1:0] in_rs1_tag,
  input  logic [ROB_W-1:0] in_rs2_tag,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_data,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_data,
  output logic             has_to_alu,
  output logic [5:0]       op,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [4:0]       shamt,
  output logic [ROB_W-1:0] rd_robnum,
  output logic [31:0]      rs1_oprand,
  output logic [31:0]      rs2_oprand
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [4:0]       shamt;
    logic [ROB_W-1:0] rd;
    logic             rs1_ready;
    logic [31:0]      rs1_val;
    logic [ROB_W-1:0] rs1_tag;
    logic             rs2_ready;
    logic [31:0]      rs2_val;
    logic [ROB_W-1:0] rs2_tag;
  } entry_t;

  entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;

  logic [RS_SIZE-1:0] wake1, wake2, can_issue;
  logic [31:0]        wval1 [RS_SIZE];
  logic [31:0]        wval2 [RS_SIZE];
  logic               sel_valid, free_valid;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic [CNT_W-1:0]   occ;
  logic [RS_SIZE-1:0] busy_nxt;
  logic               do_disp;
  entry_t             disp_ent;
  logic [31:0]        iss_rs1, iss_rs2;
  logic               in1_alu, in1_lsb, in2_alu, in2_lsb;

  // Per-entry CDB snoop; ALU bus wins when both carry the same tag.
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      logic a1, l1, a2, l2;
      a1 = alu_cdb_valid && (alu_cdb_tag == ent[i].rs1_tag);
      l1 = lsb_cdb_valid && (lsb_cdb_tag == ent[i].rs1_tag);
      a2 = alu_cdb_valid && (alu_cdb_tag == ent[i].rs2_tag);
      l2 = lsb_cdb_valid && (lsb_cdb_tag == ent[i].rs2_tag);
      wake1[i] = busy[i] && !ent[i].rs1_ready && (a1 || l1);
      wake2[i] = busy[i] && !ent[i].rs2_ready && (a2 || l2);
      wval1[i] = a1 ? alu_cdb_data : lsb_cdb_data;
      wval2[i] = a2 ? alu_cdb_data : lsb_cdb_data;
    end
  end

  // Issue candidates; entries dispatched this cycle are not yet busy.
  always_comb begin
    can_issue = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
`ifdef ALU_RS_WAKEUP_ISSUE_EN
      can_issue[i] = busy[i] && (ent[i].rs1_ready || wake1[i])
                             && (ent[i].rs2_ready || wake2[i]);
`else
      can_issue[i] = busy[i] && ent[i].rs1_ready && ent[i].rs2_ready;
`endif
    end
  end

  // Lowest-index pickers for issue and allocation, plus occupancy count.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    free_valid = 1'b0;
    free_idx   = '0;
    occ        = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (can_issue[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_valid = 1'b1;
        free_idx   = IDX_W'(i);
      end
      occ = occ + CNT_W'(busy[i]);
    end
  end

  assign rs_full = (occ >= CNT_W'(RS_SIZE - 1));

  // Issue operands, optionally forwarded from this cycle's CDB.
  always_comb begin
`ifdef ALU_RS_WAKEUP_ISSUE_EN
    iss_rs1 = ent[sel_idx].rs1_ready ? ent[sel_idx].rs1_val : wval1[sel_idx];
    iss_rs2 = ent[sel_idx].rs2_ready ? ent[sel_idx].rs2_val : wval2[sel_idx];
`else
    iss_rs1 = ent[sel_idx].rs1_val;
    iss_rs2 = ent[sel_idx].rs2_val;
`endif
  end

  // Incoming entry, with operands snooped from the CDB in the dispatch cycle.
  always_comb begin
    in1_alu = alu_cdb_valid && (alu_cdb_tag == in_rs1_tag);
    in1_lsb = lsb_cdb_valid && (lsb_cdb_tag == in_rs1_tag);
    in2_alu = alu_cdb_valid && (alu_cdb_tag == in_rs2_tag);
    in2_lsb = lsb_cdb_valid && (lsb_cdb_tag == in_rs2_tag);
    disp_ent.op        = in_op;
    disp_ent.imm       = in_imm;
    disp_ent.pc        = in_pc;
    disp_ent.shamt     = in_shamt;
    disp_ent.rd        = in_rd_robnum;
    disp_ent.rs1_tag   = in_rs1_tag;
    disp_ent.rs2_tag   = in_rs2_tag;
    disp_ent.rs1_ready = in_rs1_ready || in1_alu || in1_lsb;
    disp_ent.rs2_ready = in_rs2_ready || in2_alu || in2_lsb;
    disp_ent.rs1_val   = in_rs1_ready ? in_rs1_val : (in1_alu ? alu_cdb_data : lsb_cdb_data);
    disp_ent.rs2_val   = in_rs2_ready ? in_rs2_val : (in2_alu ? alu_cdb_data : lsb_cdb_data);
  end

  // Next busy vector; a full-station dispatch is dropped.
  always_comb begin
    do_disp  = has_to_rs && free_valid;
    busy_nxt = busy;
    if (sel_valid) busy_nxt[sel_idx] = 1'b0;
    if (do_disp)   busy_nxt[free_idx] = 1'b1;
  end

  // State and registered issue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      has_to_alu <= 1'b0;
      op         <= '0;
      imm        <= '0;
      pc         <= '0;
      shamt      <= '0;
      rd_robnum  <= '0;
      rs1_oprand <= '0;
      rs2_oprand <= '0;
    end else if (rdy) begin
      if (has_misbranch) begin
        busy       <= '0;
        has_to_alu <= 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (wake1[i]) begin
            ent[i].rs1_ready <= 1'b1;
            ent[i].rs1_val   <= wval1[i];
          end
          if (wake2[i]) begin
            ent[i].rs2_ready <= 1'b1;
            ent[i].rs2_val   <= wval2[i];
          end
        end
        if (do_disp) ent[free_idx] <= disp_ent;
        busy       <= busy_nxt;
        has_to_alu <= sel_valid;
        if (sel_valid) begin
          op         <= ent[sel_idx].op;
          imm        <= ent[sel_idx].imm;
          pc         <= ent[sel_idx].pc;
          shamt      <= ent[sel_idx].shamt;
          rd_robnum  <= ent[sel_idx].rd;
          rs1_oprand <= iss_rs1;
          rs2_oprand <= iss_rs2;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs (RS_SIZE=8, ROB_W=4). Expectations track
// ALU_RS_WAKEUP_ISSUE_EN when the same macro is defined for the bench.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, has_misbranch, has_to_rs;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc;
  logic [4:0]  in_shamt;
  logic [3:0]  in_rd_robnum;
  logic        in_rs1_ready, in_rs2_ready;
  logic [31:0] in_rs1_val, in_rs2_val;
  logic [3:0]  in_rs1_tag, in_rs2_tag;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        has_to_alu;
  logic [5:0]  op;
  logic [31:0] imm, pc;
  logic [4:0]  shamt;
  logic [3:0]  rd_robnum;
  logic [31:0] rs1_oprand, rs2_oprand;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .has_to_rs(has_to_rs), .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
    .in_shamt(in_shamt), .in_rd_robnum(in_rd_robnum),
    .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
    .has_to_alu(has_to_alu), .op(op), .imm(imm), .pc(pc), .shamt(shamt),
    .rd_robnum(rd_robnum), .rs1_oprand(rs1_oprand), .rs2_oprand(rs2_oprand)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; has_misbranch = 1'b0; has_to_rs = 1'b0;
    in_op = '0; in_imm = '0; in_pc = '0; in_shamt = '0; in_rd_robnum = '0;
    in_rs1_ready = 1'b0; in_rs2_ready = 1'b0; in_rs1_val = '0; in_rs2_val = '0;
    in_rs1_tag = '0; in_rs2_tag = '0;
    alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_data = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
  endtask

  task automatic disp(input logic [5:0] o, input logic [31:0] im, input logic [31:0] p,
                      input logic [3:0] rd,
                      input logic r1r, input logic [31:0] r1v, input logic [3:0] r1t,
                      input logic r2r, input logic [31:0] r2v, input logic [3:0] r2t);
    has_to_rs = 1'b1; in_op = o; in_imm = im; in_pc = p; in_shamt = 5'd0;
    in_rd_robnum = rd;
    in_rs1_ready = r1r; in_rs1_val = r1v; in_rs1_tag = r1t;
    in_rs2_ready = r2r; in_rs2_val = r2v; in_rs2_tag = r2t;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({has_to_alu, rs_full} !== 2'b00) begin
      failures++; $display("FAIL reset_flags got=%b want=00", {has_to_alu, rs_full});
    end
    checks++;
    if ({op, imm, pc, shamt, rd_robnum, rs1_oprand, rs2_oprand} !== '0) begin
      failures++; $display("FAIL reset_payload got op=%h imm=%h pc=%h rd=%h rs1=%h rs2=%h want all 0",
                           op, imm, pc, rd_robnum, rs1_oprand, rs2_oprand);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    disp(6'h13, 32'd3, 32'h100, 4'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
    step(); idle();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL addi_no_same_edge got=%b want=0", has_to_alu);
    end
    step();
    checks++;
    if ({has_to_alu, op, rs1_oprand, imm, rd_robnum, pc} !== {1'b1, 6'h13, 32'd5, 32'd3, 4'd2, 32'h100}) begin
      failures++; $display("FAIL addi_issue got has=%b op=%h rs1=%h imm=%h rd=%h pc=%h want 1 13 5 3 2 100",
                           has_to_alu, op, rs1_oprand, imm, rd_robnum, pc);
    end
    // ALU result for rob 2 comes back; nothing waits on it.
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'd8;
    step(); idle();
    checks++;
    if ({has_to_alu, imm} !== {1'b0, 32'd3}) begin
      failures++; $display("FAIL addi_pulse_hold got has=%b imm=%h want 0 3", has_to_alu, imm);
    end
  endtask

  task automatic test_wakeup();
    disp(6'h01, 32'd0, 32'h104, 4'd5, 1'b0, 32'd0, 4'd4, 1'b1, 32'd7, 4'd0);
    step(); idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_data = 32'h33;
    step(); idle();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL wake_wrong_tag got=%b want=0", has_to_alu);
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd4; alu_cdb_data = 32'd10;
    step(); idle();
`ifndef ALU_RS_WAKEUP_ISSUE_EN
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL wake_early got=%b want=0", has_to_alu);
    end
    step();
`endif
    checks++;
    if ({has_to_alu, rs1_oprand, rs2_oprand, rd_robnum} !== {1'b1, 32'd10, 32'd7, 4'd5}) begin
      failures++; $display("FAIL wake_issue got has=%b rs1=%h rs2=%h rd=%h want 1 a 7 5",
                           has_to_alu, rs1_oprand, rs2_oprand, rd_robnum);
    end
    step();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL wake_pulse got=%b want=0", has_to_alu);
    end
  endtask

  task automatic test_full_back_to_back();
    for (int k = 0; k < 7; k++) begin
      disp(6'h02, 32'(k), 32'h300, 4'(8 + k), 1'b0, 32'd0, 4'd6, 1'b1, 32'(k), 4'd0);
      step();
      if (k == 5) begin
        checks++;
        if (rs_full !== 1'b0) begin
          failures++; $display("FAIL full_at6 got=%b want=0", rs_full);
        end
      end
    end
    idle();
    checks++;
    if ({rs_full, has_to_alu} !== 2'b10) begin
      failures++; $display("FAIL full_at7 got full,has=%b want=10", {rs_full, has_to_alu});
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd6; alu_cdb_data = 32'h100;
    step(); idle();
`ifndef ALU_RS_WAKEUP_ISSUE_EN
    checks++;
    if ({rs_full, has_to_alu} !== 2'b10) begin
      failures++; $display("FAIL full_wake_cycle got full,has=%b want=10", {rs_full, has_to_alu});
    end
    step();
`endif
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, rs_full} !== {1'b1, 4'(8 + k), 32'h100, 32'(k), 1'b0}) begin
        failures++; $display("FAIL b2b_issue%0d got has=%b rd=%h rs1=%h rs2=%h full=%b want 1 %h 100 %h 0",
                             k, has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, rs_full, 4'(8 + k), k);
      end
      step();
    end
    checks++;
    if ({has_to_alu, rs_full} !== 2'b00) begin
      failures++; $display("FAIL b2b_drained got has,full=%b want=00", {has_to_alu, rs_full});
    end
  endtask

  task automatic test_dispatch_snoop();
    disp(6'h03, 32'd0, 32'h200, 4'd3, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd9; lsb_cdb_data = 32'hDEAD;
    step(); idle();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL snoop_same_edge got=%b want=0", has_to_alu);
    end
    step();
    checks++;
    if ({has_to_alu, rs1_oprand, rs2_oprand, rd_robnum} !== {1'b1, 32'd1, 32'hDEAD, 4'd3}) begin
      failures++; $display("FAIL snoop_lsb got has=%b rs1=%h rs2=%h rd=%h want 1 1 dead 3",
                           has_to_alu, rs1_oprand, rs2_oprand, rd_robnum);
    end
    // Both buses carry tag 5: the ALU value must be taken.
    disp(6'h04, 32'd0, 32'h204, 4'd4, 1'b0, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd5; alu_cdb_data = 32'h1111;
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd5; lsb_cdb_data = 32'h2222;
    step(); idle();
    step();
    checks++;
    if ({has_to_alu, rs1_oprand, rs2_oprand, rd_robnum} !== {1'b1, 32'h1111, 32'd2, 4'd4}) begin
      failures++; $display("FAIL snoop_alu_wins got has=%b rs1=%h rs2=%h rd=%h want 1 1111 2 4",
                           has_to_alu, rs1_oprand, rs2_oprand, rd_robnum);
    end
    step();
  endtask

  task automatic test_misbranch();
    for (int k = 0; k < 3; k++) begin
      disp(6'h06, 32'd0, 32'h400, 4'(k), 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0);
      step();
    end
    disp(6'h07, 32'd0, 32'h40C, 4'd12, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    step();
    disp(6'h07, 32'd0, 32'h410, 4'd13, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0);
    has_misbranch = 1'b1;
    step(); idle();
    checks++;
    if ({has_to_alu, rs_full} !== 2'b00) begin
      failures++; $display("FAIL flush_next got has,full=%b want=00", {has_to_alu, rs_full});
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd7; alu_cdb_data = 32'h77;
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (has_to_alu !== 1'b0) begin
        failures++; $display("FAIL flush_quiet%0d got=%b want=0", k, has_to_alu);
      end
      step();
    end
  endtask

  task automatic test_stall();
    disp(6'h08, 32'd0, 32'h500, 4'd1, 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0);
    step();
    disp(6'h05, 32'h77, 32'h504, 4'd11, 1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 4'd0);
    step(); idle();
    step();
    checks++;
    if ({has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, imm} !== {1'b1, 4'd11, 32'h55, 32'h66, 32'h77}) begin
      failures++; $display("FAIL stall_pre got has=%b rd=%h rs1=%h rs2=%h imm=%h want 1 b 55 66 77",
                           has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, imm);
    end
    rdy = 1'b0;
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd13; alu_cdb_data = 32'h999;
    disp(6'h09, 32'd0, 32'h508, 4'd14, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, imm} !== {1'b1, 4'd11, 32'h55, 32'h66, 32'h77}) begin
        failures++; $display("FAIL stall_frozen%0d got has=%b rd=%h rs1=%h rs2=%h imm=%h want 1 b 55 66 77",
                             k, has_to_alu, rd_robnum, rs1_oprand, rs2_oprand, imm);
      end
    end
    idle();
    step();
    checks++;
    if ({has_to_alu, rs2_oprand} !== {1'b0, 32'h66}) begin
      failures++; $display("FAIL stall_no_capture got has=%b rs2=%h want 0 66", has_to_alu, rs2_oprand);
    end
    step();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL stall_no_dispatch got=%b want=0", has_to_alu);
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd13; alu_cdb_data = 32'h42;
    step(); idle();
`ifndef ALU_RS_WAKEUP_ISSUE_EN
    step();
`endif
    checks++;
    if ({has_to_alu, rd_robnum, rs1_oprand} !== {1'b1, 4'd1, 32'h42}) begin
      failures++; $display("FAIL stall_late_wake got has=%b rd=%h rs1=%h want 1 1 42",
                           has_to_alu, rd_robnum, rs1_oprand);
    end
    step();
    checks++;
    if (has_to_alu !== 1'b0) begin
      failures++; $display("FAIL stall_end got=%b want=0", has_to_alu);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wakeup();
    test_full_back_to_back();
    test_dispatch_snoop();
    test_misbranch();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
